// File: rtl/snn_core_pkg.sv
// Shared state/error encodings and default widths for the SNN core tick tracker.
package snn_core_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_TMO_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_READY  = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_OVERFLOW    = 2'd1,
    ERR_OVERDELIVER = 2'd2,
    ERR_ABORT       = 2'd3
  } err_e;

endpackage

// File: rtl/pkt_sat_counter.sv
// Saturating per-channel packet counter; clr_i restarts the count from this cycle's increment.
module pkt_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  logic [W-1:0] cnt_q;

  assign at_max_o = &cnt_q;
  assign cnt_o    = cnt_q;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= W'(inc_i);
    end else if (inc_i && !at_max_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/core_tick_tracker.sv
// Tracks packets expected from neighbour channels versus packets delivered per tick window.
// Optional idle-timeout abort is enabled by defining TICK_TIMEOUT_EN.
module core_tick_tracker
  import snn_core_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TMO_W  = DEF_TMO_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       ch_ren,
  input  logic                    local_wen,
  input  logic [TMO_W-1:0]        tmo_limit,
  output logic                    tick_ready,
  output logic                    wait_packets,
  output logic [CNT_W-1:0]        pending,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic                    error,
  output logic [1:0]              err_code
);

  localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);
  localparam int DW    = CNT_W + 1;

  state_e            state_q, state_d;
  err_e              err_q, err_d, err_det;
  logic [CNT_W-1:0]  exp_q, exp_d, del_q, del_d, pend_q, pend_d;
  logic              tick_ready_q, wait_q, error_q;
  logic [NUM_CH-1:0] ch_at_max, ch_inc;
  logic              ch_clr;
  logic [SUM_W-1:0]  pop, exp_sum;
  logic [DW-1:0]     del_sum;
  logic              any_ev, seed, complete, ovf, tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pkt_sat_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (ch_clr),
        .inc_i   (ch_inc[gi]),
        .cnt_o   (ch_count[gi*CNT_W +: CNT_W]),
        .at_max_o(ch_at_max[gi])
      );
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + SUM_W'(ch_ren[i]);
  end

  // In READY the counters restart from zero with this cycle's events.
  assign any_ev   = (|ch_ren) | local_wen;
  assign seed     = (state_q == ST_READY);
  assign exp_sum  = (seed ? '0 : SUM_W'(exp_q)) + pop;
  assign del_sum  = (seed ? '0 : {1'b0, del_q}) + DW'(local_wen);
  assign ovf      = (|exp_sum[SUM_W-1:CNT_W]) | del_sum[CNT_W] | (~seed & (|(ch_ren & ch_at_max)));
  assign complete = !any_ev && (exp_q != '0) && (del_q == exp_q);

`ifdef TICK_TIMEOUT_EN
  localparam int TW1 = TMO_W + 1;
  logic [TMO_W-1:0] idle_q, idle_d;

  assign tmo_hit = (state_q == ST_ACTIVE) && !any_ev && !complete && (tmo_limit != '0) &&
                   (({1'b0, idle_q} + TW1'(1)) >= {1'b0, tmo_limit});
  assign idle_d  = (state_q == ST_ACTIVE && !any_ev) ? ((&idle_q) ? idle_q : idle_q + TMO_W'(1)) : '0;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^tmo_limit;
  assign tmo_hit    = 1'b0;
`endif

  // Priority: overflow, then over-delivery, then abort.
  always_comb begin
    err_det = ERR_NONE;
    if (ovf)                                               err_det = ERR_OVERFLOW;
    else if (SUM_W'(del_sum) > exp_sum)                    err_det = ERR_OVERDELIVER;
    else if (state_q == ST_ACTIVE && (tick || tmo_hit))    err_det = ERR_ABORT;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    exp_d   = exp_q;
    del_d   = del_q;
    ch_clr  = 1'b0;
    ch_inc  = '0;
    case (state_q)
      ST_IDLE, ST_ACTIVE, ST_READY: begin
        if (state_q == ST_ACTIVE || any_ev) begin
          if (err_det != ERR_NONE) begin
            state_d = ST_ERR;
            err_d   = err_det;
          end else begin
            exp_d   = exp_sum[CNT_W-1:0];
            del_d   = del_sum[CNT_W-1:0];
            ch_inc  = ch_ren;
            ch_clr  = seed;
            state_d = (complete && state_q == ST_ACTIVE) ? ST_READY : ST_ACTIVE;
          end
        end else if (seed) begin
          state_d = ST_IDLE;
          exp_d   = '0;
          del_d   = '0;
          ch_clr  = 1'b1;
        end
      end
      ST_ERR: begin
        if (tick) begin
          state_d = ST_IDLE;
          err_d   = ERR_NONE;
          exp_d   = '0;
          del_d   = '0;
          ch_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pend_d = (del_d >= exp_d) ? '0 : exp_d - del_d;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      err_q        <= ERR_NONE;
      exp_q        <= '0;
      del_q        <= '0;
      pend_q       <= '0;
      tick_ready_q <= 1'b0;
      wait_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      exp_q        <= exp_d;
      del_q        <= del_d;
      pend_q       <= pend_d;
      tick_ready_q <= (state_d == ST_READY);
      wait_q       <= (state_d == ST_ACTIVE);
      error_q      <= (state_d == ST_ERR);
    end
  end

  assign tick_ready   = tick_ready_q;
  assign wait_packets = wait_q;
  assign pending      = pend_q;
  assign error        = error_q;
  assign err_code     = err_q;

endmodule

// File: doc/core_tick_tracker.md
CORE_TICK_TRACKER -- requirements
Module: core_tick_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of neighbour input channels counted (W,E,N,S order, bit 0 = west).
REQ-002 SHALL have parameter CNT_W, default 8, width of all packet counters.
REQ-003 SHALL have parameter TMO_W, default 16, width of idle-timeout counter and limit.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on falling edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port tick  in  1  global tick pulse, one cycle.
REQ-007 SHALL have port ch_ren  in  NUM_CH  per-channel packet-accepted strobes.
REQ-008 SHALL have port local_wen  in  1  packet delivered to scheduler strobe.
REQ-009 SHALL have port tmo_limit  in  TMO_W  idle-timeout limit in cycles; 0 disables.
REQ-010 SHALL have port tick_ready  out  1  one-cycle window-complete pulse.
REQ-011 SHALL have port wait_packets  out  1  high while window open and incomplete.
REQ-012 SHALL have port pending  out  CNT_W  expected minus delivered.
REQ-013 SHALL have port ch_count  out  NUM_CH*CNT_W  per-channel accepted counts, flattened, channel 0 in LSBs.
REQ-014 SHALL have port error  out  1  sticky error flag.
REQ-015 SHALL have port err_code  out  2  0 none, 1 overflow, 2 over-delivery, 3 timeout/abort.

Function
REQ-016 expected SHALL increment each cycle by popcount(ch_ren); delivered SHALL increment by local_wen.
REQ-017 FSM states SHALL be IDLE, ACTIVE, READY, ERR.
REQ-018 IDLE->ACTIVE SHALL occur on first cycle with any ch_ren or local_wen; that cycle's events are counted.
REQ-019 ACTIVE->READY SHALL occur when delivered==expected, expected!=0, and no ch_ren/local_wen that cycle.
REQ-020 READY SHALL last exactly one cycle with tick_ready=1, then clear all counters and go IDLE.
REQ-021 Events arriving during READY SHALL seed the next window (counters load that cycle's events, next state ACTIVE).
REQ-022 Any counter reaching 2^CNT_W-1 and incremented SHALL saturate, set err_code=1, go ERR.
REQ-023 delivered exceeding expected SHALL set err_code=2, go ERR.
REQ-024 tick while ACTIVE SHALL set err_code=3, go ERR; tick in IDLE/READY SHALL be ignored.
REQ-025 ERR SHALL hold counters frozen and error=1 until next tick, then clear counters, error, err_code and go IDLE.
REQ-026 First error detected SHALL win; simultaneous errors priority 1>2>3.
REQ-027 wait_packets SHALL equal (state==ACTIVE); pending SHALL be 0 when delivered>=expected.
REQ-028 All outputs SHALL be registered; tick_ready SHALL never assert in two consecutive cycles.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, all counters 0, tick_ready=0, wait_packets=0, error=0, err_code=0.
REQ-030 Reset mid-window SHALL discard the window with no tick_ready or error produced.

Configuration
REQ-031 With TICK_TIMEOUT_EN defined, ACTIVE with no events for tmo_limit consecutive cycles (tmo_limit!=0) SHALL set err_code=3, go ERR.
REQ-032 Without TICK_TIMEOUT_EN, the timeout counter SHALL not exist, tmo_limit SHALL be ignored, ACTIVE may persist indefinitely.

Structure
REQ-033 FSM state enum, err_code encodings and default widths SHALL live in shared package snn_core_pkg.
REQ-034 Per-channel saturating counter SHALL be sub-module pkt_sat_counter, instantiated NUM_CH times via generate.

Verification
REQ-035 ch_ren=4'b0001 for 3 cycles, then 3 local_wen -> tick_ready one cycle after 3rd delivery, pending 3->0, ch_count[0]=3.
REQ-036 ch_ren=4'b1111 one cycle -> expected=4; 4 local_wen -> single tick_ready, others 0.
REQ-037 CNT_W=4, 16 west strobes -> count saturates 15, error=1, err_code=1; tick -> IDLE, error=0.
REQ-038 local_wen with expected=0 in ACTIVE (ch_ren=0) -> err_code=2; 2 ch_ren during READY -> next window starts expected=2.
REQ-039 TICK_TIMEOUT_EN, tmo_limit=10, one west strobe then silence -> error at 10th idle cycle, err_code=3; macro off -> no error.
REQ-040 reset_n pulsed low mid-window with pending=5 -> all outputs 0 immediately, no tick_ready afterwards.
